adc_scan_scheduler: RTL

Time-shares the on-board 4/8-channel SPI ADC (MCP300x-class, 10-bit) between several requesters: accel pedal, bus voltage and phase-current sense. Arbitrates requests round-robin, runs one complete single-ended conversion frame per grant on the AD_CLK/CS/DIN/DOUT pins, and returns the 10-bit result with its channel tag. Sits between the board-level ADC pins and the commutation/duty logic, replacing ad-hoc per-counter ADC bit-banging in the control loop.

---
 rtl/adc_sched_pkg.sv | 42 ++++
 rtl/adc_spi_frame.sv | 98 +++++++++
 rtl/adc_scan_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC scan scheduler.
// Frame geometry, averaging constants and round-robin pick helper.
package adc_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_SETUP,
    S_SHIFT,
    S_GAP
  } state_t;

  localparam int DATA_W = 10;
  localparam int CMD_BITS = 5;
  localparam int FRAME_PERIODS = 17;
  localparam int FIRST_DATA_PERIOD = 7;
  localparam int AVG_N = 4;
  localparam int AVG_SHIFT = 2;
  localparam int SUM_W = 12;

  // First set request after ptr, wrapping modulo n.
  function automatic logic [2:0] rr_pick(
    input logic [7:0] r,
    input logic [2:0] ptr,
    input int         n
  );
    logic [2:0] g;
    logic       hit;
    int         idx;
    g   = ptr;
    hit = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = (int'(ptr) + i) % n;
      if (!hit && i <= n && r[idx[2:0]]) begin
        g   = idx[2:0];
        hit = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/adc_spi_frame.sv
// One SETUP+SHIFT single-ended conversion frame on the SPI pins.
// Owns the SCLK half-period counter, command shifting and capture.
module adc_spi_frame
  import adc_sched_pkg::*;
#(
  parameter int CLK_DIV = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        chan,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              sclk,
  output logic              cs,
  output logic              din,
  input  logic              dout
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int LAST_HALF = 2 * FRAME_PERIODS;
  localparam int H_W = $clog2(LAST_HALF + 1);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [H_W-1:0]   half;
  logic [H_W-1:0]   nh;
  logic [2:0]       chan_q;
  logic [4:0]       period;
  logic             cnt_end;

  function automatic logic cmd_bit(
    input logic [4:0] p,
    input logic [2:0] c
  );
    logic b;
    case (p)
      5'd0:    b = 1'b1;
      5'd1:    b = 1'b1;
      5'd2:    b = c[2];
      5'd3:    b = c[1];
      5'd4:    b = c[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Half 0 is setup; half 1+2p is low phase of period p, 2+2p high.
  assign cnt_end = (cnt == CNT_W'(CLK_DIV - 1));
  assign nh      = half + 1'b1;
  assign period  = 5'(half >> 1);
  assign done    = active & cnt_end & (half == H_W'(LAST_HALF));

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      half   <= '0;
      chan_q <= '0;
      cs     <= 1'b1;
      sclk   <= 1'b0;
      din    <= 1'b0;
      result <= '0;
    end else if (start && !active) begin
      active <= 1'b1;
      cnt    <= '0;
      half   <= '0;
      chan_q <= chan;
      cs     <= 1'b0;
      sclk   <= 1'b0;
      din    <= 1'b1;
      result <= '0;
    end else if (active) begin
      if (!cnt_end) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        if (done) begin
          active <= 1'b0;
          cs     <= 1'b1;
          sclk   <= 1'b0;
          din    <= 1'b0;
        end else begin
          half <= nh;
          if (nh[0]) begin
            sclk <= 1'b0;
            din  <= cmd_bit(period, chan_q);
          end else begin
            sclk <= 1'b1;
            if (period >= 5'(FIRST_DATA_PERIOD))
              result <= {result[DATA_W-2:0], dout};
          end
        end
      end
    end
  end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Round-robin scheduler sharing one SPI ADC among N_CH requesters.
// Define ADC_AVG_EN to average 4 frames per grant.
module adc_scan_scheduler
  import adc_sched_pkg::*;
#(
  parameter int CLK_DIV = 27,
  parameter int N_CH    = 4,
  parameter int CS_HIGH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req,
  output logic [N_CH-1:0]   ack,
  output logic              valid,
  output logic [2:0]        ch,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              AD_CLK,
  output logic              CS,
  output logic              DIN,
  input  logic              DOUT
);

  localparam int GAP_LEN = CS_HIGH * CLK_DIV;
  localparam int GAP_W = $clog2(GAP_LEN);

  state_t            state;
  state_t            state_nx;
  logic [2:0]        g;
  logic [2:0]        g_pick;
  logic [2:0]        rr_ptr;
  logic [GAP_W-1:0]  gap_cnt;
  logic              gap_end;
  logic              start;
  logic              frame_done;
  logic              fin;
  logic              more;
  logic [DATA_W-1:0] result;
  logic [7:0]        ack_w;

`ifdef ADC_AVG_EN
  logic [1:0]       frame_cnt;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sum_nx;
  assign sum_nx = sum + SUM_W'(result);
  // Counter wraps to zero after the last frame of a grant.
  assign more   = (frame_cnt != 2'd0);
`else
  assign more   = 1'b0;
`endif

  assign g_pick  = rr_pick(8'(req), rr_ptr, N_CH);
  assign gap_end = (gap_cnt == GAP_W'(GAP_LEN - 1));
  assign fin     = frame_done & (state == S_SHIFT);
  assign ack_w   = 8'd1 << g;

  adc_spi_frame #(
    .CLK_DIV(CLK_DIV)
  ) u_frame (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .chan  (g),
    .done  (frame_done),
    .result(result),
    .sclk  (AD_CLK),
    .cs    (CS),
    .din   (DIN),
    .dout  (DOUT)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    busy     = (state != S_IDLE);
    unique case (state)
      S_IDLE:  if (|req) state_nx = S_ARB;
      S_ARB:   state_nx = S_SETUP;
      S_SETUP: begin
        start    = 1'b1;
        state_nx = S_SHIFT;
      end
      S_SHIFT: if (frame_done) state_nx = S_GAP;
      S_GAP: begin
        if (gap_end) begin
          if (more)       state_nx = S_SETUP;
          else if (|req)  state_nx = S_ARB;
          else            state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= 3'(N_CH - 1);
      g         <= '0;
      gap_cnt   <= '0;
      ack       <= '0;
      valid     <= 1'b0;
      data      <= '0;
      ch        <= '0;
`ifdef ADC_AVG_EN
      frame_cnt <= '0;
      sum       <= '0;
`endif
    end else begin
      ack   <= '0;
      valid <= 1'b0;
      if (state == S_GAP && !gap_end) gap_cnt <= gap_cnt + 1'b1;
      else                            gap_cnt <= '0;
      if (state == S_ARB) begin
        g      <= g_pick;
        rr_ptr <= g_pick;
`ifdef ADC_AVG_EN
        frame_cnt <= '0;
        sum       <= '0;
`endif
      end
`ifdef ADC_AVG_EN
      if (fin) begin
        sum       <= sum_nx;
        frame_cnt <= frame_cnt + 1'b1;
        if (frame_cnt == 2'(AVG_N - 1)) begin
          valid <= 1'b1;
          ack   <= ack_w[N_CH-1:0];
          data  <= sum_nx[SUM_W-1:AVG_SHIFT];
          ch    <= g;
        end
      end
`else
      if (fin) begin
        valid <= 1'b1;
        ack   <= ack_w[N_CH-1:0];
        data  <= result;
        ch    <= g;
      end
`endif
    end
  end

endmodule
